sap_control_sequencer: RTL and testbench
========================================

# sap_control_sequencer

Control sequencer for the SAP 8-bit processor. It is the counterpart of the instruction decoder on the step handshake. It runs the two-cycle fetch (PC→MAR, RAM→IR) and then the execute phase. During execute it drives `fetch_complete` and `step` to the decoder and consumes `steps_required` from it. It also drives the memory/IR/PC-output control signals that the decoder leaves to the controller.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `opcode`  in  4  IR[7:4], valid from the cycle after `ir_load`.
- `steps_required`  in  2  execute length from decoder (combinational from `opcode`).
- `fetch_complete`  out  1  high in every EXEC cycle.
- `step`  out  2  execute step index; 0 outside EXEC.
- `pc_out`  out  1  PC drives bus.
- `mar_load`  out  1  MAR captures bus.
- `ram_read`  out  1  RAM drives bus.
- `ir_load`  out  1  IR captures bus.
- `instr_done`  out  1  one-cycle pulse in the last EXEC step.
- `step_mode`, `step_req`  in  1 each  single-step control; present only with `SAP_SINGLE_STEP_EN`.

## Operation
- States: BOOT, FETCH_ADDR, FETCH_MEM, EXEC.
  - With the macro there is also WAIT.
- BOOT:
  - All outputs 0.
  - Next state FETCH_ADDR, or WAIT when single-step is enabled and `step_mode`=1.
- FETCH_ADDR:
  - `pc_out`=1, `mar_load`=1.
  - Next state FETCH_MEM.
- FETCH_MEM:
  - `ram_read`=1, `ir_load`=1.
  - Next state EXEC, with the step counter cleared to 0.
- EXEC:
  - `fetch_complete`=1, `step`=counter.
  - Let last = `steps_required`−1. A `steps_required` of 0 is treated as 1, so last=0.
  - If counter == last: assert `instr_done`, clear the counter, go to FETCH_ADDR (or WAIT in step mode).
  - Otherwise increment the counter.
- Operand memory strobes in EXEC, decoded from `opcode` and `step`:
  - `mar_load`=1 at step 0 for opcodes 0011, 0100, 0101, 0110 (LOAD A, LOAD B, STORE A, STORE B).
  - `ram_read`=1 at steps 1 and 2 for 0011 and 0100.
  - Nothing else is driven in EXEC. ALU, register, PC-increment and jump strobes belong to the decoder.
- The counter is 2 bits wide and never exceeds 2, because `steps_required` is at most 3.
- `step_req` is ignored when `step_mode`=0.

## Timing
- Reset values:
  - state = BOOT, counter = 0.
  - All outputs 0 while `reset` is high and during the first cycle after its release.
- Reset mid-instruction: outputs drop to 0 asynchronously. The partial instruction is abandoned and restarts from BOOT. PC handling is the PC block's concern.
- All outputs are decoded combinationally from registered state, counter and `opcode`. Loads take effect on the rising edge that ends the cycle.
- Instruction length is 2 + `steps_required` cycles:
  - NOP: 3 cycles.
  - MOV, ADD, etc.: 4 cycles.
  - LOAD: 5 cycles.
- `steps_required` is sampled every EXEC cycle. The decoder may change it with the step (a taken vs. not-taken jump is fixed per instruction, so this is stable in practice).
- No bus contention: at most one of `pc_out` and `ram_read` is high in any cycle.

## Configuration
- `SAP_SINGLE_STEP_EN` defined:
  - Adds the `step_mode` and `step_req` ports and the WAIT state.
  - WAIT: all outputs 0. Leaves to FETCH_ADDR on a cycle where `step_req`=1 or `step_mode`=0.
  - `step_req` held high executes one instruction per visit to WAIT; it is level-sampled and not edge-detected.
- `SAP_SINGLE_STEP_EN` undefined:
  - Ports and the WAIT state are absent.
  - The sequencer free-runs.

## Structure
- Shared package `sap_pkg`: state enum; opcode constants (NOP, MOV_A … DEC_A); step width constant (2).
- The instruction decoder imports the same opcode constants.
- Single module; no sub-module needed.
  - The execute step counter stays inline, since it is coupled to the state transitions.

## Test plan
- Reset, then `opcode`=0000, `steps_required`=1 → states BOOT, FA, FM, EXEC, FA; `fetch_complete` high exactly 1 cycle; `instr_done` pulses in that cycle.
- `opcode`=0011, `steps_required`=3 → EXEC `step` sequence 0,1,2; `mar_load` at step 0; `ram_read` at steps 1–2; 5 cycles per instruction.
- `opcode`=0101, `steps_required`=2 → `mar_load` at step 0; `ram_read` never high in EXEC; return to FA after step 1.
- `steps_required`=0 forced → single EXEC cycle with `step`=0, then FA.
- Assert `reset` during EXEC step 1 of a LOAD → all outputs 0 in the same cycle; after release, one BOOT cycle, then FA with `step`=0.
- Macro on, `step_mode`=1, `step_req`=0 for 10 cycles → held in WAIT, all outputs 0; one-cycle `step_req` → exactly one instruction executes, then back to WAIT.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP definitions: sequencer state encoding, opcode constants, step width.
// WAIT state exists only when SAP_SINGLE_STEP_EN is defined.
package sap_pkg;

    localparam int STEP_W = 2;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_MOV_A   = 4'b0001;
    localparam logic [3:0] OP_MOV_B   = 4'b0010;
    localparam logic [3:0] OP_LOAD_A  = 4'b0011;
    localparam logic [3:0] OP_LOAD_B  = 4'b0100;
    localparam logic [3:0] OP_STORE_A = 4'b0101;
    localparam logic [3:0] OP_STORE_B = 4'b0110;
    localparam logic [3:0] OP_ADD     = 4'b0111;
    localparam logic [3:0] OP_SUB     = 4'b1000;
    localparam logic [3:0] OP_JMP     = 4'b1001;
    localparam logic [3:0] OP_JZ      = 4'b1010;
    localparam logic [3:0] OP_OUT     = 4'b1011;
    localparam logic [3:0] OP_INC_A   = 4'b1100;
    localparam logic [3:0] OP_DEC_A   = 4'b1101;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH_ADDR,
        S_FETCH_MEM,
`ifdef SAP_SINGLE_STEP_EN
        S_EXEC,
        S_WAIT
`else
        S_EXEC
`endif
    } sap_state_e;

    // Opcodes that put an operand address on the MAR in the first execute step.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD_A) || (op == OP_LOAD_B) ||
               (op == OP_STORE_A) || (op == OP_STORE_B);
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == OP_LOAD_A) || (op == OP_LOAD_B);
    endfunction

endpackage

// File: rtl/sap_control_sequencer.sv
// SAP fetch/execute sequencer driving the decoder step handshake and memory strobes.
// Optional single-step mode (step_mode/step_req ports, WAIT state) via SAP_SINGLE_STEP_EN.
module sap_control_sequencer
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
`ifdef SAP_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_req,
`endif
    input  logic [3:0]        opcode,
    input  logic [STEP_W-1:0] steps_required,
    output logic              fetch_complete,
    output logic [STEP_W-1:0] step,
    output logic              pc_out,
    output logic              mar_load,
    output logic              ram_read,
    output logic              ir_load,
    output logic              instr_done
);

    sap_state_e        state;
    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] last;
    logic              wait_next;

    // A zero step count still gets one execute cycle.
    assign last = (steps_required == '0) ? '0 : steps_required - 1'b1;

`ifdef SAP_SINGLE_STEP_EN
    assign wait_next = step_mode;
`else
    assign wait_next = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_BOOT;
            cnt   <= '0;
        end else begin
            case (state)
                S_BOOT: begin
`ifdef SAP_SINGLE_STEP_EN
                    state <= wait_next ? S_WAIT : S_FETCH_ADDR;
`else
                    state <= S_FETCH_ADDR;
`endif
                end
                S_FETCH_ADDR: state <= S_FETCH_MEM;
                S_FETCH_MEM: begin
                    state <= S_EXEC;
                    cnt   <= '0;
                end
                S_EXEC: begin
                    if (cnt == last) begin
                        cnt <= '0;
`ifdef SAP_SINGLE_STEP_EN
                        state <= wait_next ? S_WAIT : S_FETCH_ADDR;
`else
                        state <= S_FETCH_ADDR;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SAP_SINGLE_STEP_EN
                S_WAIT: begin
                    if (step_req || !step_mode)
                        state <= S_FETCH_ADDR;
                end
`endif
                default: begin
                    state <= S_BOOT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        fetch_complete = 1'b0;
        step           = '0;
        pc_out         = 1'b0;
        mar_load       = 1'b0;
        ram_read       = 1'b0;
        ir_load        = 1'b0;
        instr_done     = 1'b0;
        case (state)
            S_FETCH_ADDR: begin
                pc_out   = 1'b1;
                mar_load = 1'b1;
            end
            S_FETCH_MEM: begin
                ram_read = 1'b1;
                ir_load  = 1'b1;
            end
            S_EXEC: begin
                fetch_complete = 1'b1;
                step           = cnt;
                instr_done     = (cnt == last);
                mar_load       = is_mem_op(opcode) && (cnt == 2'd0);
                ram_read       = is_load_op(opcode) && ((cnt == 2'd1) || (cnt == 2'd2));
            end
            default: ;
        endcase
    end

    logic unused_wait;
    assign unused_wait = wait_next;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized self-checking bench for sap_control_sequencer against a per-instruction cycle model.
// Exercises single-step mode when SAP_SINGLE_STEP_EN is defined.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_mode = 1'b0;
    logic       step_req = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [1:0] steps_required = 2'd1;
    logic       fetch_complete, pc_out, mar_load, ram_read, ir_load, instr_done;
    logic [1:0] step;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk            (clk),
        .reset          (reset),
`ifdef SAP_SINGLE_STEP_EN
        .step_mode      (step_mode),
        .step_req       (step_req),
`endif
        .opcode         (opcode),
        .steps_required (steps_required),
        .fetch_complete (fetch_complete),
        .step           (step),
        .pc_out         (pc_out),
        .mar_load       (mar_load),
        .ram_read       (ram_read),
        .ir_load        (ir_load),
        .instr_done     (instr_done)
    );

    // {fetch_complete, step[1:0], pc_out, mar_load, ram_read, ir_load, instr_done}
    function automatic logic [7:0] outs();
        return {fetch_complete, step, pc_out, mar_load, ram_read, ir_load, instr_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs of one whole instruction, built from the fetch/execute rules.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] sr, input string tag);
        logic [7:0] exp_q[$];
        int n_exec;
        logic mem_op, ld_op;
        opcode = op;
        steps_required = sr;
        step_req = 1'b0;
        n_exec = (sr == 0) ? 1 : int'(sr);
        mem_op = (op >= 4'd3) && (op <= 4'd6);
        ld_op  = (op == 4'd3) || (op == 4'd4);
        exp_q.push_back(8'b0_00_11000);
        exp_q.push_back(8'b0_00_00110);
        for (int k = 0; k < n_exec; k++) begin
            logic [7:0] v;
            v = '0;
            v[7]   = 1'b1;
            v[6:5] = 2'(k);
            v[3]   = mem_op && (k == 0);
            v[2]   = ld_op && (k == 1 || k == 2);
            v[0]   = (k == n_exec - 1);
            exp_q.push_back(v);
        end
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk($sformatf("%s op=%0h sr=%0d cyc%0d", tag, op, sr, i), 32'(outs()), 32'(exp_q[i]));
            chk($sformatf("%s bus", tag), 32'(pc_out & ram_read), 32'd0);
            tick();
        end
    endtask

    task automatic chk_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk($sformatf("%s cyc%0d", tag, i), 32'(outs()), 32'd0);
            tick();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'd0);
        tick();
        reset = 1'b0;
        chk_idle("boot", 1);

        run_instr(4'h0, 2'd1, "nop");
        run_instr(4'h3, 2'd3, "load_a");
        run_instr(4'h4, 2'd3, "load_b");
        run_instr(4'h5, 2'd2, "store_a");
        run_instr(4'h6, 2'd2, "store_b");
        run_instr(4'h7, 2'd0, "sr0");
        run_instr(4'h3, 2'd0, "sr0_load");

        for (int i = 0; i < 60; i++)
            run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "rand");

        // Reset in EXEC step 1 of a LOAD: FA, FM, step0, then step1.
        opcode = 4'h3;
        steps_required = 2'd3;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_rst_step", 32'(step), 32'd1);
        #1 reset = 1'b1;
        #1 chk("rst_mid_async", 32'(outs()), 32'd0);
        tick();
        reset = 1'b0;
        chk_idle("boot2", 1);
        run_instr(4'h3, 2'd3, "after_rst");

`ifdef SAP_SINGLE_STEP_EN
        step_mode = 1'b1;
        run_instr(4'h1, 2'd2, "enter_wait");
        chk_idle("wait", 10);
        step_req = 1'b1;
        @(negedge clk);
        chk("wait_req", 32'(outs()), 32'd0);
        tick();
        run_instr(4'h3, 2'd3, "single");
        chk_idle("wait2", 3);
        step_req = 1'b1;
        tick();
        run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "single2");
        chk_idle("wait3", 2);
        step_mode = 1'b0;
        step_req = 1'b1;
        chk_idle("wait_exit", 1);
        run_instr(4'h4, 2'd3, "free");
        step_req = 1'b0;
`endif

        for (int i = 0; i < 10; i++)
            run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
